// File: rtl/prm_grid_pkg.sv
// Shared constants and types for the PRM occupancy-grid collision sequencer.
// Grid coordinates: X is a bit index within a word, and {Z,Y} is the word address.
package prm_grid_pkg;

    localparam int GRID_ADDR_W = 11;
    localparam int GRID_DATA_W = 32;

    localparam logic [4:0] X_MAX = 5'd31;
    localparam logic [5:0] Y_MAX = 6'd63;
    localparam logic [4:0] Z_MAX = 5'd31;

    localparam logic [1:0] SLOT_ZY   = 2'd0;
    localparam logic [1:0] SLOT_ZY1  = 2'd1;
    localparam logic [1:0] SLOT_Z1Y  = 2'd2;
    localparam logic [1:0] SLOT_Z1Y1 = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} grid_state_e;

    // One tag travels alongside each presented slot until its read data returns.
    typedef struct packed {
        logic       v;
        logic       inb;
        logic [1:0] slot;
    } slot_tag_t;

endpackage

// File: rtl/grid_mask_gen.sv
// Expands one registered mass point into the X window mask, the four {Z,Y}
// neighbour addresses and their in-bound flags. Purely combinational.
module grid_mask_gen
    import prm_grid_pkg::*;
(
    input  logic [4:0]                  x,
    input  logic [5:0]                  y,
    input  logic [4:0]                  z,
    output logic [GRID_DATA_W-1:0]      mask,
    output logic [3:0][GRID_ADDR_W-1:0] addr,
    output logic [3:0]                  inb
);

    logic       y_ok;
    logic       z_ok;
    logic [5:0] y1;
    logic [4:0] z1;

    always_comb begin
        y_ok = (y != Y_MAX);
        z_ok = (z != Z_MAX);
        y1   = y + 6'd1;
        z1   = z + 5'd1;

        // The window never wraps: X=31 covers only the top bit.
        mask = GRID_DATA_W'(1) << x;
        if (x != X_MAX) begin
            mask = mask | (GRID_DATA_W'(1) << (x + 5'd1));
        end

        addr[SLOT_ZY]   = {z,  y};
        addr[SLOT_ZY1]  = {z,  y1};
        addr[SLOT_Z1Y]  = {z1, y};
        addr[SLOT_Z1Y1] = {z1, y1};

        inb[SLOT_ZY]   = 1'b1;
        inb[SLOT_ZY1]  = y_ok;
        inb[SLOT_Z1Y]  = z_ok;
        inb[SLOT_Z1Y1] = y_ok & z_ok;
    end

endmodule

// File: rtl/grid_collision_seq.sv
// Sequences the four neighbour-cell grid reads for one mass point and returns
// a single collision verdict. The slot timing is fixed, and out-of-bound slots still occupy their cycle.
module grid_collision_seq
    import prm_grid_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        massX,
    input  logic [5:0]        massY,
    input  logic [4:0]        massZ,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_collide,
    output logic [3:0]        rsp_hitMask,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Once raised, rsp_valid and rsp_* stay stable until that transfer.

    grid_state_e state_q, state_d;
    logic [4:0]  x_q;
    logic [5:0]  y_q;
    logic [4:0]  z_q;
    logic [1:0]  slot_q, slot_d;
    logic [3:0]  hit_q, hit_d;
    slot_tag_t   tag_q [RD_LAT];
    slot_tag_t   tag_in;
    slot_tag_t   chk_tag;
    logic        accept;
    logic        checking;
    logic        hit_now;
    logic        stop_now;
    logic        tags_pending;

    logic [GRID_DATA_W-1:0]      cell_mask;
    logic [3:0][GRID_ADDR_W-1:0] cell_addr;
    logic [3:0]                  cell_inb;

    grid_mask_gen u_mask_gen (
        .x    (x_q),
        .y    (y_q),
        .z    (z_q),
        .mask (cell_mask),
        .addr (cell_addr),
        .inb  (cell_inb)
    );

    assign chk_tag   = tag_q[RD_LAT-1];
    assign dbg_state = state_q;

    // Data arriving this cycle belongs to the oldest tag.
    // Younger tags decide whether DRAIN must keep waiting.
    always_comb begin
        checking     = (state_q == ISSUE) || (state_q == DRAIN);
        hit_now      = checking && chk_tag.v && chk_tag.inb &&
                       ((mem_rdata & DATA_W'(cell_mask)) != '0);
        stop_now     = (EARLY_EXIT != 0) && hit_now;
        tags_pending = 1'b0;
        for (int k = 0; k < RD_LAT - 1; k++) begin
            tags_pending = tags_pending | tag_q[k].v;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        hit_d       = hit_q;
        accept      = 1'b0;
        tag_in      = '0;
        req_ready   = 1'b0;
        mem_en      = 1'b0;
        mem_addr    = '0;
        rsp_valid   = 1'b0;
        rsp_collide = 1'b0;
        rsp_hitMask = 4'b0000;

        if (hit_now) begin
            hit_d[chk_tag.slot] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                    slot_d  = SLOT_ZY;
                    hit_d   = 4'b0000;
                end
            end
            ISSUE: begin
                tag_in.v    = 1'b1;
                tag_in.inb  = cell_inb[slot_q];
                tag_in.slot = slot_q;
                if (cell_inb[slot_q] && !stop_now) begin
                    mem_en   = 1'b1;
                    mem_addr = ADDR_W'(cell_addr[slot_q]);
                end
                slot_d = slot_q + 2'd1;
                if (stop_now) begin
                    state_d = RESP;
                end else if (slot_q == SLOT_Z1Y1) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (stop_now || !tags_pending) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid   = 1'b1;
                rsp_collide = |hit_q;
                rsp_hitMask = hit_q;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tags are flushed on accept, so reads left over from an early exit cannot leak into the next request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            slot_q  <= 2'd0;
            hit_q   <= 4'b0000;
            x_q     <= 5'd0;
            y_q     <= 6'd0;
            z_q     <= 5'd0;
            for (int k = 0; k < RD_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            hit_q   <= hit_d;
            if (accept) begin
                x_q <= massX;
                y_q <= massY;
                z_q <= massZ;
            end
            tag_q[0] <= accept ? '0 : tag_in;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_q[k] <= accept ? '0 : tag_q[k-1];
            end
        end
    end

endmodule

// File: tb/tb_grid_collision_seq.sv
// Bench for grid_collision_seq: three DUT lanes (EARLY_EXIT/RD_LAT variants),
// each with its own grid RAM model, checked every cycle against a behavioural model.
module tb_grid_collision_seq;

    localparam int NL = 3;
    localparam int LAT [NL] = '{1, 1, 3};
    localparam int EE  [NL] = '{1, 0, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst         [NL];
    logic        req_valid   [NL];
    logic        req_ready   [NL];
    logic [4:0]  mx          [NL];
    logic [5:0]  my          [NL];
    logic [4:0]  mz          [NL];
    logic        mem_en      [NL];
    logic [10:0] mem_addr    [NL];
    logic [31:0] mem_rdata   [NL];
    logic        rsp_valid   [NL];
    logic        rsp_ready   [NL];
    logic        rsp_collide [NL];
    logic [3:0]  rsp_hit     [NL];
    logic [1:0]  dbg         [NL];

    logic [31:0] mem     [NL][2048];
    logic [31:0] rd_pipe [NL][3];
    logic [4:0]  exp_q[$];

    int checks = 0;
    int errors = 0;

    grid_collision_seq #(.RD_LAT(1), .EARLY_EXIT(1)) u_dut0 (
        .CLK(clk), .RST(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .massX(mx[0]), .massY(my[0]), .massZ(mz[0]), .mem_en(mem_en[0]), .mem_addr(mem_addr[0]),
        .mem_rdata(mem_rdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_collide(rsp_collide[0]), .rsp_hitMask(rsp_hit[0]), .dbg_state(dbg[0]));

    grid_collision_seq #(.RD_LAT(1), .EARLY_EXIT(0)) u_dut1 (
        .CLK(clk), .RST(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .massX(mx[1]), .massY(my[1]), .massZ(mz[1]), .mem_en(mem_en[1]), .mem_addr(mem_addr[1]),
        .mem_rdata(mem_rdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_collide(rsp_collide[1]), .rsp_hitMask(rsp_hit[1]), .dbg_state(dbg[1]));

    grid_collision_seq #(.RD_LAT(3), .EARLY_EXIT(1)) u_dut2 (
        .CLK(clk), .RST(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .massX(mx[2]), .massY(my[2]), .massZ(mz[2]), .mem_en(mem_en[2]), .mem_addr(mem_addr[2]),
        .mem_rdata(mem_rdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_collide(rsp_collide[2]), .rsp_hitMask(rsp_hit[2]), .dbg_state(dbg[2]));

    // Grid RAM: random garbage when not enabled, so ignored slots must really be ignored.
    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            rd_pipe[l][0] <= mem_en[l] ? mem[l][mem_addr[l]] : $urandom;
            rd_pipe[l][1] <= rd_pipe[l][0];
            rd_pipe[l][2] <= rd_pipe[l][1];
        end
    end
    assign mem_rdata[0] = rd_pipe[0][0];
    assign mem_rdata[1] = rd_pipe[1][0];
    assign mem_rdata[2] = rd_pipe[2][2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: which cycles after accept read which cell, when the
    // response appears, and which slots it reports.
    task automatic model(input int l, input logic [4:0] x, input logic [5:0] y, input logic [4:0] z,
                         output logic [15:0] en, output logic [15:0][10:0] ad,
                         output logic [15:0] zad, output int rc, output logic [3:0] hm);
        logic [31:0] m;
        logic [3:0]  hits;
        logic [3:0]  inb;
        int          a [4];
        int          cy, cz, first;
        m = '0;
        for (int b = 0; b < 32; b++) begin
            if (b == int'(x) || b == int'(x) + 1) m[b] = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            cy      = int'(y) + (i % 2);
            cz      = int'(z) + (i / 2);
            inb[i]  = (cy <= 63) && (cz <= 31);
            a[i]    = cz * 64 + cy;
            hits[i] = 1'b0;
            if (inb[i]) hits[i] = ((mem[l][a[i]] & m) != 0);
        end
        first = -1;
        if (EE[l] != 0) begin
            for (int i = 0; i < 4; i++) begin
                if (hits[i] && first < 0) first = i;
            end
        end
        en  = '0;
        ad  = '0;
        zad = '0;
        hm  = '0;
        if (first >= 0) begin
            rc        = 2 + first + LAT[l];
            hm[first] = 1'b1;
        end else begin
            rc = 5 + LAT[l];
            hm = hits;
        end
        for (int i = 0; i < 4; i++) begin
            if (1 + i < rc - 1) begin
                if (inb[i]) begin
                    en[1+i] = 1'b1;
                    ad[1+i] = a[i][10:0];
                end else begin
                    zad[1+i] = 1'b1;
                end
            end
        end
    endtask

    // One request from accept (cycle 0) through the response handshake, checked every cycle.
    task automatic do_req(input int l, input logic [4:0] x, input logic [5:0] y, input logic [4:0] z,
                          input int hold);
        logic [15:0]       en;
        logic [15:0][10:0] ad;
        logic [15:0]       zad;
        int                rc;
        logic [3:0]        hm;
        logic [4:0]        exp_r;
        model(l, x, y, z, en, ad, zad, rc, hm);
        exp_q.push_back({|hm, hm});
        exp_r = '0;
        check($sformatf("L%0d c0 req_ready", l), req_ready[l], 1);
        req_valid[l] = 1'b1;
        mx[l] = x;
        my[l] = y;
        mz[l] = z;
        @(negedge clk);
        req_valid[l] = 1'b0;
        mx[l] = 5'($urandom);
        my[l] = 6'($urandom);
        mz[l] = 5'($urandom);
        for (int k = 1; k <= rc + hold; k++) begin
            check($sformatf("L%0d c%0d mem_en", l, k), mem_en[l], en[k]);
            if (en[k]) check($sformatf("L%0d c%0d mem_addr", l, k), mem_addr[l], ad[k]);
            if (zad[k]) check($sformatf("L%0d c%0d oob mem_addr", l, k), mem_addr[l], 0);
            check($sformatf("L%0d c%0d req_ready", l, k), req_ready[l], 0);
            check($sformatf("L%0d c%0d rsp_valid", l, k), rsp_valid[l], k >= rc);
            if (k == rc) exp_r = exp_q.pop_front();
            if (k >= rc) begin
                check($sformatf("L%0d c%0d rsp_collide", l, k), rsp_collide[l], exp_r[4]);
                check($sformatf("L%0d c%0d rsp_hitMask", l, k), rsp_hit[l], exp_r[3:0]);
            end
            if (k == rc + hold) rsp_ready[l] = 1'b1;
            @(negedge clk);
        end
        rsp_ready[l] = 1'b0;
        check($sformatf("L%0d post req_ready", l), req_ready[l], 1);
        check($sformatf("L%0d post rsp_valid", l), rsp_valid[l], 0);
    endtask

    // Reset asserted during cycle 3 of a request; the request must vanish.
    task automatic do_rst_mid(input int l, input logic [4:0] x, input logic [5:0] y, input logic [4:0] z);
        req_valid[l] = 1'b1;
        mx[l] = x;
        my[l] = y;
        mz[l] = z;
        @(negedge clk);
        req_valid[l] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst[l] = 1'b1;
        @(negedge clk);
        rst[l] = 1'b0;
        check($sformatf("L%0d rst_mid mem_en", l), mem_en[l], 0);
        check($sformatf("L%0d rst_mid rsp_valid", l), rsp_valid[l], 0);
        check($sformatf("L%0d rst_mid req_ready", l), req_ready[l], 1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("L%0d rst_mid quiet%0d rsp_valid", l, k), rsp_valid[l], 0);
            check($sformatf("L%0d rst_mid quiet%0d mem_en", l, k), mem_en[l], 0);
        end
    endtask

    task automatic rand_cell(input int l, input int addr, input logic [4:0] x);
        int sel;
        sel = $urandom_range(0, 5);
        case (sel)
            0, 1:    mem[l][addr] = 32'd0;
            2:       mem[l][addr] = 32'd1 << x;
            3:       mem[l][addr] = 32'd1 << ((int'(x) + 1) % 32);
            4:       mem[l][addr] = $urandom & ~(32'd3 << x);
            default: mem[l][addr] = $urandom;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0]       en;
        logic [15:0][10:0] ad;
        logic [15:0]       zad;
        int                rc;
        logic [3:0]        hm;
        logic [4:0]        x;
        logic [5:0]        y;
        logic [4:0]        z;

        // clock/reset
        for (int l = 0; l < NL; l++) begin
            rst[l] = 1'b1;
            req_valid[l] = 1'b0;
            rsp_ready[l] = 1'b0;
            mx[l] = '0;
            my[l] = '0;
            mz[l] = '0;
            for (int a = 0; a < 2048; a++) mem[l][a] = 32'd0;
        end
        repeat (2) @(negedge clk);
        for (int l = 0; l < NL; l++) begin
            check($sformatf("L%0d reset req_ready", l), req_ready[l], 1);
            check($sformatf("L%0d reset mem_en", l), mem_en[l], 0);
            check($sformatf("L%0d reset mem_addr", l), mem_addr[l], 0);
            check($sformatf("L%0d reset rsp_valid", l), rsp_valid[l], 0);
            check($sformatf("L%0d reset rsp_collide", l), rsp_collide[l], 0);
            check($sformatf("L%0d reset rsp_hitMask", l), rsp_hit[l], 0);
            rst[l] = 1'b0;
        end
        @(negedge clk);

        // Empty grid, interior point
        model(1, 5'd5, 6'd10, 5'd3, en, ad, zad, rc, hm);
        check("pin1 en", en[4:0], 5'b11110);
        check("pin1 addr1", ad[1], 11'h0CA);
        check("pin1 addr2", ad[2], 11'h0CB);
        check("pin1 addr3", ad[3], 11'h10A);
        check("pin1 addr4", ad[4], 11'h10B);
        check("pin1 rc", rc, 6);
        check("pin1 hm", hm, 4'b0000);
        for (int l = 0; l < NL; l++) do_req(l, 5'd5, 6'd10, 5'd3, 0);

        // Early exit on a slot-2 hit at X+1
        mem[0][11'h10A] = 32'h0000_0040;
        mem[2][11'h10A] = 32'h0000_0040;
        model(0, 5'd5, 6'd10, 5'd3, en, ad, zad, rc, hm);
        check("pin2 en", en[4:0], 5'b01110);
        check("pin2 rc", rc, 5);
        check("pin2 hm", hm, 4'b0100);
        do_req(0, 5'd5, 6'd10, 5'd3, 0);
        do_req(2, 5'd5, 6'd10, 5'd3, 0);
        mem[0][11'h10A] = 32'd0;
        mem[2][11'h10A] = 32'd0;

        // Corner point: only slot 0 in bounds, X window is only bit 31
        mem[0][11'h7FF] = 32'h4000_0000;
        model(0, 5'd31, 6'd63, 5'd31, en, ad, zad, rc, hm);
        check("pin3a en", en[4:0], 5'b00010);
        check("pin3a addr1", ad[1], 11'h7FF);
        check("pin3a rc", rc, 6);
        check("pin3a hm", hm, 4'b0000);
        do_req(0, 5'd31, 6'd63, 5'd31, 0);
        mem[0][11'h7FF] = 32'h8000_0000;
        model(0, 5'd31, 6'd63, 5'd31, en, ad, zad, rc, hm);
        check("pin3b rc", rc, 3);
        check("pin3b hm", hm, 4'b0001);
        do_req(0, 5'd31, 6'd63, 5'd31, 0);
        mem[1][11'h7FF] = 32'h8000_0000;
        do_req(1, 5'd31, 6'd63, 5'd31, 0);

        // No early exit: hits in slots 1 and 3
        mem[1][11'h0CB] = 32'h0000_0020;
        mem[1][11'h10B] = 32'h0000_0040;
        model(1, 5'd5, 6'd10, 5'd3, en, ad, zad, rc, hm);
        check("pin4 rc", rc, 6);
        check("pin4 hm", hm, 4'b1010);
        do_req(1, 5'd5, 6'd10, 5'd3, 0);

        // Response back-pressure, then an immediate follow-up request
        do_req(1, 5'd5, 6'd10, 5'd3, 3);
        do_req(1, 5'd7, 6'd20, 5'd9, 0);

        // Reset in the middle of a request
        do_rst_mid(0, 5'd5, 6'd10, 5'd3);
        do_rst_mid(2, 5'd5, 6'd10, 5'd3);
        do_req(2, 5'd5, 6'd10, 5'd3, 1);

        // Randomized requests with boundary-biased coordinates
        for (int l = 0; l < NL; l++) begin
            for (int n = 0; n < 40; n++) begin
                x = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom);
                y = ($urandom_range(0, 4) == 0) ? 6'd63 : 6'($urandom);
                z = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom);
                for (int i = 0; i < 4; i++) begin
                    if (int'(y) + (i % 2) <= 63 && int'(z) + (i / 2) <= 31)
                        rand_cell(l, (int'(z) + i / 2) * 64 + int'(y) + (i % 2), x);
                end
                do_req(l, x, y, z, $urandom_range(0, 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grid_collision_seq.md
Name: grid_collision_seq

Overview:
- Sequences occupancy-grid lookups for one mass point (massX, massY, massZ) as part of PRM collision checking.
- Expands the point into a 2-bit X window and four {Z,Y} neighbour cells, then reads each cell word from a single-port grid RAM (2048 x 32).
- ANDs each returned word with the X window mask and returns one collision verdict per request through a valid/ready handshake.

Parameters:
- ADDR_W, 11, grid RAM address width ({Z[4:0],Y[5:0]}).
- DATA_W, 32, grid word width (one bit per X).
- RD_LAT, 1, grid RAM read latency in cycles; legal values 1..3.
- EARLY_EXIT, 1, if 1, stop issuing reads after the first hit.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- massX  in  5  X coordinate (bit index in word).
- massY  in  6  Y coordinate.
- massZ  in  5  Z coordinate.
- mem_en  out  1  grid RAM read enable.
- mem_addr  out  ADDR_W  grid RAM read address.
- mem_rdata  in  DATA_W  grid RAM read data, valid RD_LAT cycles after mem_en.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts result.
- rsp_collide  out  1  any checked cell hit the X mask.
- rsp_hitMask  out  4  per-slot hit flags.

Behaviour:
- Reset: go to IDLE. req_ready=1; mem_en=0; mem_addr=0; rsp_valid=0; rsp_collide=0; rsp_hitMask=0. Any in-flight read tags are cleared.
- Reset mid-operation: the pending request is dropped. mem_en=0 from the following cycle, and no response is produced.
- Accept: a request is accepted in cycle 0 when req_valid and req_ready are both high. massX/Y/Z are registered at accept. req_ready=1 only in IDLE.
- X mask: bit X is set. Bit X+1 is also set if X<31. No wrap, so X=31 gives mask 0x80000000.
- Slots and addresses (address = {Z,Y}, plain concatenation):
  - Slot 0: (Z,Y), always in bounds.
  - Slot 1: (Z,Y+1), in bounds if Y<63.
  - Slot 2: (Z+1,Y), in bounds if Z<31.
  - Slot 3: (Z+1,Y+1), in bounds if Y<63 and Z<31.
- Out-of-bounds slots: not read and never hit. Their cycle is still consumed (mem_en=0, mem_addr=0), so timing is fixed.
- FSM states: IDLE -> ISSUE -> DRAIN -> RESP -> IDLE.
- ISSUE: slot i is presented in cycle 1+i (i=0..3). Its data is checked in cycle 1+i+RD_LAT against a registered slot tag pipeline (RD_LAT deep).
- DRAIN: entered after slot 3 is presented; waits until the last tagged data has been checked.
- RESP: rsp_valid is asserted in cycle 6 for RD_LAT=1 (generally 5+RD_LAT). rsp_* holds stable until rsp_ready; IDLE follows in the cycle after the handshake.
- Hit rule: (mem_rdata & mask)!=0 for an in-bound slot sets rsp_hitMask[slot]. rsp_collide = OR of rsp_hitMask.
- EARLY_EXIT=1: a hit observed in cycle c suppresses mem_en combinationally in cycle c and in all later cycles. Data of reads already issued is ignored. rsp_valid is asserted in cycle c+1, and rsp_hitMask holds only the first hit.
- EARLY_EXIT=0: all four slots are always processed.
- Back-to-back requests: the earliest next accept is the cycle after the rsp handshake. No overlap between requests.

Decomposition:
- Shared package (prm_grid_pkg):
  - GRID_ADDR_W=11, GRID_DATA_W=32, X_MAX=31, Y_MAX=63, Z_MAX=31.
  - Slot index constants SLOT_ZY..SLOT_Z1Y1.
  - FSM state enum {IDLE, ISSUE, DRAIN, RESP}.
- Sub-module grid_mask_gen: combinational; from (X,Y,Z) produces the 32-bit mask, four addresses and a 4-bit in-bound vector. The FSM, tag pipeline and response registers stay in grid_collision_seq.

Test Plan:
1. X=5, Y=10, Z=3, memory all zero, RD_LAT=1:
   - mem_addr=0x0CA, 0x0CB, 0x10A, 0x10B with mem_en in cycles 1-4.
   - rsp_valid in cycle 6 with collide=0, hitMask=0000.
2. Same point, word[0x10A]=0x00000040 (bit X+1), EARLY_EXIT=1:
   - mem_en in cycles 1-3 only (cycle 4 suppressed).
   - rsp_valid in cycle 5 with collide=1, hitMask=0100.
3. X=31, Y=63, Z=31, word[0x7FF]=0x40000000:
   - mem_en only in cycle 1, addr 0x7FF.
   - collide=0 (mask 0x80000000). With word=0x80000000 instead: collide=1, hitMask=0001.
4. EARLY_EXIT=0, hits in slots 1 and 3 -> rsp in cycle 6, hitMask=1010, collide=1.
5. Hold rsp_ready=0 for 3 cycles after rsp_valid:
   - rsp_* stable and req_ready=0 throughout.
   - After the handshake, a second request is accepted the very next cycle (req_ready=1).
6. Assert RST in cycle 3 of a request:
   - Next cycle: mem_en=0, rsp_valid=0, req_ready=1.
   - No response is ever emitted for the dropped request.
